approx_sum_error_monitor: RTL and testbench

//  Consumer side of the approximate-adder datapath. Accepts operand/result samples
//  {A,B,Cin,S_apx,Cout_apx} from an 8-bit approximate adder under test.

---
 rtl/apx_mon_pkg.sv | 17 +
 rtl/apx_ed_calc.sv | 61 ++++++
 rtl/approx_sum_error_monitor.sv | 177 +++++++++++++++++
 tb/tb_approx_sum_error_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apx_mon_pkg.sv
// Shared types and defaults for the approximate-adder error monitor.
package apx_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_WINDOW = 256;
  localparam int unsigned DEF_ACC_W  = 24;
  localparam int unsigned DEF_ED_W   = DEF_WIDTH + 1;
  localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/apx_ed_calc.sv
// Stage 1 of the monitor pipeline: registers the exact and approximate sums, and
// combinationally forms the error distance |exact - apx|. Optional: APXMON_CAPTURE_EN.
module apx_ed_calc
  import apx_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s_apx,
  input  logic             cout_apx,
  output logic             valid,
  output logic [WIDTH:0]   ed
`ifdef APXMON_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin
`endif
);

  logic [WIDTH:0] exact;
  logic [WIDTH:0] apx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      exact <= '0;
      apx   <= '0;
    end else begin
      valid <= load;
      if (load) begin
        exact <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        apx   <= {cout_apx, s_apx};
      end
    end
  end

`ifdef APXMON_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
    end else if (load) begin
      op_a   <= a;
      op_b   <= b;
      op_cin <= cin;
    end
  end
`endif

  always_comb begin
    ed = (exact >= apx) ? (exact - apx) : (apx - exact);
  end

endmodule

// File: rtl/approx_sum_error_monitor.sv
// Error-statistics monitor for an approximate adder: windowed ED count/max/sum.
// Optional: APXMON_CAPTURE_EN adds capture of the first erroneous sample's operands.
module approx_sum_error_monitor
  import apx_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_s_apx,
  input  logic             in_cout_apx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
`ifdef APXMON_CAPTURE_EN
  ,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic             cap_cin
`endif
);

  localparam int unsigned ED_W  = WIDTH + 1;
  localparam int unsigned SUM_W = ((ACC_W > ED_W) ? ACC_W : ED_W) + 1;

  state_t          state;
  logic            xfer;
  logic            go;
  logic            last_xfer;
  logic            s1_valid;
  logic [ED_W-1:0] s1_ed;
  logic            s2_valid;
  logic [ED_W-1:0] s2_ed;
  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] sum_next;

  always_comb begin
    in_ready  = (state == RUN);
    busy      = (state == RUN) || (state == DRAIN);
    xfer      = in_valid && in_ready;
    go        = start && ((state == IDLE) || (state == REPORT));
    last_xfer = xfer && (sample_count == CNT_W'(WINDOW - 1));
  end

`ifdef APXMON_CAPTURE_EN
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [WIDTH-1:0] s2_a;
  logic [WIDTH-1:0] s2_b;
  logic             s2_cin;
`endif

  apx_ed_calc #(
    .WIDTH(WIDTH)
  ) u_ed_calc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (xfer),
    .a        (in_a),
    .b        (in_b),
    .cin      (in_cin),
    .s_apx    (in_s_apx),
    .cout_apx (in_cout_apx),
    .valid    (s1_valid),
    .ed       (s1_ed)
`ifdef APXMON_CAPTURE_EN
    ,
    .op_a     (s1_a),
    .op_b     (s1_b),
    .op_cin   (s1_cin)
`endif
  );

  // No new samples enter in DRAIN, so once stage 1 is empty the stage-2 entry
  // retires on this same edge and the statistics are final after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (last_xfer) state <= DRAIN;
        DRAIN:   if (!s1_valid) begin
                   state <= REPORT;
                   done  <= 1'b1;
                 end
        REPORT:  if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_ed    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_ed    <= s1_ed;
    end
  end

  always_comb begin
    sum_wide = SUM_W'(sum_ed) + SUM_W'(s2_ed);
    sum_next = (sum_wide > SUM_W'({ACC_W{1'b1}})) ? '1 : sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else if (go) begin
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else begin
      if (xfer) sample_count <= sample_count + 1'b1;
      if (s2_valid) begin
        if (s2_ed != '0) err_count <= err_count + 1'b1;
        if (s2_ed > max_ed) max_ed <= s2_ed;
        sum_ed <= sum_next;
      end
    end
  end

`ifdef APXMON_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_a   <= '0;
      s2_b   <= '0;
      s2_cin <= 1'b0;
    end else begin
      s2_a   <= s1_a;
      s2_b   <= s1_b;
      s2_cin <= s1_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_cin   <= 1'b0;
    end else if (go) begin
      cap_valid <= 1'b0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_cin   <= 1'b0;
    end else if (s2_valid && (s2_ed != '0) && !cap_valid) begin
      cap_valid <= 1'b1;
      cap_a     <= s2_a;
      cap_b     <= s2_b;
      cap_cin   <= s2_cin;
    end
  end
`endif

endmodule

// File: tb/tb_approx_sum_error_monitor.sv
// Randomized self-checking bench for approx_sum_error_monitor against a plain
// arithmetic model of windowed error-distance statistics.
module tb_approx_sum_error_monitor;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned WINDOW = 4;
  localparam int unsigned ACC_W  = 9;
  localparam int unsigned SAT    = (1 << ACC_W) - 1;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned cin;
    int unsigned s;
    int unsigned cout;
  } sample_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic [WIDTH-1:0] in_s_apx = '0;
  logic             in_cout_apx = 1'b0;
  logic             busy;
  logic             done;
  logic [15:0]      sample_count;
  logic [15:0]      err_count;
  logic [WIDTH:0]   max_ed;
  logic [ACC_W-1:0] sum_ed;
`ifdef APXMON_CAPTURE_EN
  logic             cap_valid;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_cin;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  sample_t     win [WINDOW];

  approx_sum_error_monitor #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .in_s_apx     (in_s_apx),
    .in_cout_apx  (in_cout_apx),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .max_ed       (max_ed),
    .sum_ed       (sum_ed)
`ifdef APXMON_CAPTURE_EN
    ,
    .cap_valid    (cap_valid),
    .cap_a        (cap_a),
    .cap_b        (cap_b),
    .cap_cin      (cap_cin)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int unsigned ed_of(input sample_t x);
    int unsigned exact = x.a + x.b + x.cin;
    int unsigned apx   = x.cout * 256 + x.s;
    return (exact > apx) ? exact - apx : apx - exact;
  endfunction

  function automatic sample_t mk(input int unsigned a, input int unsigned b,
                                 input int unsigned cin, input int unsigned apx);
    sample_t x;
    x.a = a; x.b = b; x.cin = cin; x.s = apx % 256; x.cout = apx / 256;
    return x;
  endfunction

  task automatic gen_random();
    for (int i = 0; i < WINDOW; i++) begin
      int unsigned a, b, c, ex, apx, kind;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 1);
      ex = a + b + c;
      kind = $urandom_range(0, 2);
      if (kind == 0)      apx = ex;
      else if (kind == 1) apx = (ex + $urandom_range(0, 6) + 509) % 512;
      else                apx = $urandom_range(0, 511);
      win[i] = mk(a, b, c, apx);
    end
  endtask

  task automatic drive_junk(input bit v);
    in_valid    = v;
    in_a        = WIDTH'($urandom_range(0, 255));
    in_b        = WIDTH'($urandom_range(0, 255));
    in_cin      = 1'($urandom_range(0, 1));
    in_s_apx    = WIDTH'($urandom_range(0, 255));
    in_cout_apx = 1'($urandom_range(0, 1));
  endtask

  // Starts a window, feeds win[] under random in_valid, then checks drain/done timing
  // and the final statistics against the model.
  task automatic run_window(input int unsigned vprob, input bit mid_start, input bit start_on_done);
    int unsigned cnt = 0, guard = 0;
    int unsigned e_err = 0, e_max = 0, e_sum = 0, ed;
    bit          e_cap = 0;
    sample_t     cap;
    cap = mk(0, 0, 0, 0);
    for (int i = 0; i < WINDOW; i++) begin
      ed = ed_of(win[i]);
      if (ed != 0) begin
        e_err++;
        if (!e_cap) begin e_cap = 1; cap = win[i]; end
      end
      if (ed > e_max) e_max = ed;
      e_sum = (e_sum + ed > SAT) ? SAT : e_sum + ed;
    end

    @(negedge clk);
    start = 1'b1;
    drive_junk(0);
    @(negedge clk);
    start = 1'b0;
    check("run_ready", in_ready, 1);
    check("run_count_clear", sample_count, 0);
    check("run_sum_clear", sum_ed, 0);
`ifdef APXMON_CAPTURE_EN
    check("cap_clear", cap_valid, 0);
`endif

    while (cnt < WINDOW && guard < 400) begin
      bit v = ($urandom_range(0, 99) < vprob);
      start = mid_start && (cnt == 1);
      if (v) begin
        in_valid    = 1'b1;
        in_a        = WIDTH'(win[cnt].a);
        in_b        = WIDTH'(win[cnt].b);
        in_cin      = 1'(win[cnt].cin);
        in_s_apx    = WIDTH'(win[cnt].s);
        in_cout_apx = 1'(win[cnt].cout);
        if (in_ready) cnt++;
      end else begin
        drive_junk(0);
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (cnt < WINDOW) check("window_timeout", cnt, WINDOW);

    drive_junk($urandom_range(0, 1) == 1);
    check("drain_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    check("drain_done0", done, 0);
    @(negedge clk);
    drive_junk(1);
    check("drain_done1", done, 0);
    @(negedge clk);
    drive_junk(0);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("sample_count", sample_count, WINDOW);
    check("err_count", err_count, e_err);
    check("max_ed", max_ed, e_max);
    check("sum_ed", sum_ed, e_sum);
`ifdef APXMON_CAPTURE_EN
    check("cap_valid", cap_valid, e_cap);
    check("cap_a", cap_a, cap.a);
    check("cap_b", cap_b, cap.b);
    check("cap_cin", cap_cin, cap.cin);
`endif
    if (start_on_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("sod_busy", busy, 1);
      check("sod_done", done, 0);
      check("sod_count", sample_count, 0);
      check("sod_sum", sum_ed, 0);
    end else begin
      @(negedge clk);
      check("done_once", done, 0);
      check("report_hold", sum_ed, e_sum);
    end
  endtask

  initial begin
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", sample_count, 0);
    check("rst_err", err_count, 0);
    check("rst_max", max_ed, 0);
    check("rst_sum", sum_ed, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_accept", sample_count, 0);
    in_valid = 1'b0;

    for (int i = 0; i < WINDOW; i++) win[i] = mk(3, 5, 0, 8);
    run_window(100, 0, 0);

    win[0] = mk(8'h80, 8'h80, 0, 8'h80);
    win[1] = mk(8'hFF, 8'h01, 0, 8'hFF);
    win[2] = mk(1, 1, 0, 2);
    win[3] = mk(7, 9, 1, 17);
    run_window(100, 0, 0);

    for (int i = 0; i < WINDOW; i++) win[i] = mk(8'hFF, 8'hFF, 0, 8'hFE);
    run_window(70, 0, 0);

    for (int n = 0; n < 12; n++) begin
      gen_random();
      run_window($urandom_range(30, 100), n == 3, n == 6);
    end

    gen_random();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a = 8'h80; in_b = 8'h80; in_cin = 1'b0; in_s_apx = 8'h00; in_cout_apx = 1'b0;
      @(negedge clk);
    end
    check("pre_reset_count", sample_count, 2);
    rst_n = 1'b0;
    #1;
    check("abandon_busy", busy, 0);
    check("abandon_ready", in_ready, 0);
    check("abandon_count", sample_count, 0);
    check("abandon_sum", sum_ed, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy, 0);
    check("post_reset_err", err_count, 0);
    win[0] = mk(10, 20, 0, 30);
    win[1] = mk(8'h12, 8'h34, 1, 8'h40);
    win[2] = mk(8'hF0, 8'h20, 1, 9'h100);
    win[3] = mk(0, 0, 0, 0);
    run_window(80, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
